// File: rtl/channel_sink_fifo.sv
// Leaf sink buffer with occupancy-based latency metric; CHANNEL_SINK_FIFO_BYPASS_EN adds empty-buffer cut-through.
// Latency 1 cycle push-to-pop (0 when empty with bypass); in_ch_ready_o = !full from registered state only.
module channel_sink_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY_WIDTH = 4,
  parameter int DEPTH         = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_ch_valid_i,
  input  logic [DATA_WIDTH-1:0]    in_ch_data_i,
  output logic                     in_ch_ready_o,
  output logic [LATENCY_WIDTH-1:0] in_ch_latency_o,
  output logic                     out_valid_o,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int unsigned LAT_MAX = (1 << LATENCY_WIDTH) - 1;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            occ_d;
  logic [LATENCY_WIDTH-1:0] latency_q, latency_d;
  logic                     push, pop, cut_through;
  logic [DATA_WIDTH-1:0]    head_data;

  assign empty_o         = (wr_ptr_q == rd_ptr_q);
  assign full_o          = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign occupancy_o     = wr_ptr_q - rd_ptr_q;
  assign in_ch_ready_o   = !full_o;
  assign in_ch_latency_o = latency_q;
  assign head_data       = mem_q[rd_ptr_q[AW-1:0]];

`ifdef CHANNEL_SINK_FIFO_BYPASS_EN
  // Empty buffer forwards the input word straight through; it is only stored if the consumer stalls.
  assign out_valid_o = !empty_o || in_ch_valid_i;
  assign out_data_o  = empty_o ? in_ch_data_i : head_data;
  assign cut_through = empty_o && in_ch_valid_i && out_ready_i;
`else
  assign out_valid_o = !empty_o;
  assign out_data_o  = head_data;
  assign cut_through = 1'b0;
`endif

  assign push = in_ch_valid_i && in_ch_ready_o && !cut_through;
  assign pop  = out_valid_o && out_ready_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    occ_d    = wr_ptr_d - rd_ptr_d;
    // Saturate rather than wrap so a deep buffer never advertises itself as lightly loaded.
    if (32'(occ_d) > LAT_MAX) latency_d = LATENCY_WIDTH'(LAT_MAX);
    else                      latency_d = LATENCY_WIDTH'(occ_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      latency_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      latency_q <= latency_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q[AW-1:0]] <= in_ch_data_i;
  end
endmodule

// File: tb/tb_channel_sink_fifo.sv
// Bench for channel_sink_fifo: directed table, corner sequences and random traffic against a queue model.
module tb_channel_sink_fifo;
  localparam int DW      = 32;
  localparam int LW      = 4;
  localparam int DEPTH   = 8;
  localparam int OW      = $clog2(DEPTH) + 1;
  localparam int LAT_MAX = 2**LW - 1;
`ifdef CHANNEL_SINK_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_vld, in_rdy, out_vld, out_rdy, full, empty;
  logic [DW-1:0] in_dat, out_dat;
  logic [LW-1:0] lat;
  logic [OW-1:0] occ;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] q[$];
  int            lat_m    = 0;
  bit            model_on = 1'b0;

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic          ordy;
    int            occ;
    logic          full;
    logic          rdy;
    int            lat;
    logic [DW-1:0] odat;
  } vec_t;
  vec_t tbl[$];

  channel_sink_fifo #(.DATA_WIDTH(DW), .LATENCY_WIDTH(LW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_ch_valid_i(in_vld), .in_ch_data_i(in_dat),
    .in_ch_ready_o(in_rdy), .in_ch_latency_o(lat),
    .out_valid_o(out_vld), .out_data_o(out_dat), .out_ready_i(out_rdy),
    .occupancy_o(occ), .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int n);
    return (n > LAT_MAX) ? LAT_MAX : n;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit e, ov;
    if (!model_on) return;
    e  = (q.size() == 0);
    ov = !e || (BYP && in_vld);
    chk("occupancy", occ, q.size());
    chk("empty", empty, e);
    chk("full", full, q.size() == DEPTH);
    chk("in_ready", in_rdy, q.size() != DEPTH);
    chk("latency", lat, lat_m);
    chk("out_valid", out_vld, ov);
    if (ov) chk("out_data", out_dat, e ? in_dat : q[0]);
  endtask

  task automatic model_update();
    bit e, do_pop, do_push;
    if (rst) begin
      q.delete();
      lat_m    = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      e = (q.size() == 0);
      if (!(BYP && e && in_vld && out_rdy)) begin
        do_pop  = !e && out_rdy;
        do_push = in_vld && (q.size() < DEPTH);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(in_dat);
      end
      lat_m = sat(q.size());
    end
  endtask

  task automatic cyc_start(input logic r, input logic v, input logic [DW-1:0] d, input logic ordy);
    rst = r; in_vld = v; in_dat = d; out_rdy = ordy;
    @(negedge clk);
    model_check();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic ordy);
    cyc_start(r, v, d, ordy);
    cyc_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bias;
    vec_t v;

    // Fill 0x01..0x08, one refused push while full, drain 0x01..0x08, then idle empty.
    for (int k = 1; k <= DEPTH + 1; k++) begin
      v.vld = 1'b1; v.dat = (k <= DEPTH) ? k : 32'h99; v.ordy = 1'b0;
      v.occ = k - 1; v.full = (k == DEPTH + 1); v.rdy = (k != DEPTH + 1);
      v.lat = sat(k - 1); v.odat = 32'h1;
      tbl.push_back(v);
    end
    for (int j = 0; j < DEPTH; j++) begin
      v.vld = 1'b0; v.dat = '0; v.ordy = 1'b1;
      v.occ = DEPTH - j; v.full = (j == 0); v.rdy = (j != 0);
      v.lat = sat(DEPTH - j); v.odat = j + 1;
      tbl.push_back(v);
    end
    v.vld = 1'b0; v.dat = '0; v.ordy = 1'b0;
    v.occ = 0; v.full = 1'b0; v.rdy = 1'b1; v.lat = 0; v.odat = '0;
    tbl.push_back(v);

    step(1'b1, 1'b1, 32'hDEAD, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc_start(1'b0, tbl[i].vld, tbl[i].dat, tbl[i].ordy);
      chk($sformatf("tbl[%0d].occ", i), occ, tbl[i].occ);
      chk($sformatf("tbl[%0d].empty", i), empty, tbl[i].occ == 0);
      chk($sformatf("tbl[%0d].full", i), full, tbl[i].full);
      chk($sformatf("tbl[%0d].ready", i), in_rdy, tbl[i].rdy);
      chk($sformatf("tbl[%0d].latency", i), lat, tbl[i].lat);
      if (tbl[i].occ != 0) begin
        chk($sformatf("tbl[%0d].out_valid", i), out_vld, 1'b1);
        chk($sformatf("tbl[%0d].out_data", i), out_dat, tbl[i].odat);
      end
      cyc_end();
    end

    // Steady stream with 4 held entries across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100 + i, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc_start(1'b0, 1'b1, 32'h200 + i, 1'b1);
      chk("steady_occ", occ, 4);
      chk("steady_data", out_dat, (i < 4) ? 32'h100 + i : 32'h200 + i - 4);
      cyc_end();
    end

    // Full with pop: push refused, occupancy drops to 7.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h300 + i, 1'b0);
    cyc_start(1'b0, 1'b1, 32'h77, 1'b1);
    chk("fullpop_full", full, 1'b1);
    chk("fullpop_ready", in_rdy, 1'b0);
    cyc_end();
    cyc_start(1'b0, 1'b0, '0, 1'b0);
    chk("fullpop_occ", occ, 7);
    chk("fullpop_ready_after", in_rdy, 1'b1);
    cyc_end();

    // Reset with 5 entries held and traffic presented.
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    cyc_start(1'b0, 1'b0, '0, 1'b0);
    chk("prereset_occ", occ, 5);
    cyc_end();
    step(1'b1, 1'b1, 32'h55, 1'b1);
    cyc_start(1'b0, 1'b0, '0, 1'b0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_out_valid", out_vld, 1'b0);
    chk("reset_latency", lat, 0);
    chk("reset_ready", in_rdy, 1'b1);
    cyc_end();

    // Push 0xAA into an empty buffer with the consumer ready.
    cyc_start(1'b0, 1'b1, 32'hAA, 1'b1);
`ifdef CHANNEL_SINK_FIFO_BYPASS_EN
    chk("bypass_valid", out_vld, 1'b1);
    chk("bypass_data", out_dat, 32'hAA);
    cyc_end();
    cyc_start(1'b0, 1'b0, '0, 1'b0);
    chk("bypass_occ", occ, 0);
    cyc_end();
`else
    chk("nobypass_valid", out_vld, 1'b0);
    cyc_end();
    cyc_start(1'b0, 1'b0, '0, 1'b0);
    chk("nobypass_valid_next", out_vld, 1'b1);
    chk("nobypass_data_next", out_dat, 32'hAA);
    chk("nobypass_occ", occ, 1);
    cyc_end();
    step(1'b0, 1'b0, '0, 1'b1);
`endif

    // Random traffic in phases of differing consumer pressure.
    bias = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) bias = (i / 200) % 3 == 0 ? 20 : ((i / 200) % 3 == 1 ? 90 : 50);
      step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom,
           $urandom_range(99) < bias);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
